// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and default datapath sizing.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = 5;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. Operates on unsigned magnitudes only.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        acc_next = acc;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        ge       = 1'b0;
        if (is_div) begin
            // acc = {remainder, unconsumed dividend bits / quotient bits}
            rem_sh = acc[2*WIDTH-1:WIDTH-1];
            ge     = (rem_sh >= {1'b0, operand});
            diff   = rem_sh[WIDTH-1:0] - operand;
            if (ge) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            // acc = {partial product, unconsumed multiplier bits}
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO, with a
// start/busy/done handshake toward the hazard logic.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = MDU_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdu_state_e           state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     operand;
    logic                 is_div;
    logic                 res_neg;
    logic                 rem_neg;
    logic                 div_zero;

    logic                 is_signed;
    logic                 neg1;
    logic                 neg2;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;

    always_comb begin
        is_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
        neg1      = is_signed & src1_i[WIDTH-1];
        neg2      = is_signed & src2_i[WIDTH-1];
        mag1      = neg1 ? ('0 - src1_i) : src1_i;
        mag2      = neg2 ? ('0 - src2_i) : src2_i;
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                is_div   <= op_i[1];
                                res_neg  <= neg1 ^ neg2;
                                rem_neg  <= neg1;
                                div_zero <= op_i[1] && (src2_i == '0);
                                if (op_i[1]) begin
                                    acc     <= {{WIDTH{1'b0}}, mag1};
                                    operand <= mag2;
                                end else begin
                                    acc     <= {{WIDTH{1'b0}}, mag2};
                                    operand <= mag1;
                                end
                                cnt   <= '0;
                                state <= ST_CALC;
                            end
                            MDU_MTHI: hi_o <= src1_i;
                            MDU_MTLO: lo_o <= src1_i;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Divide by zero leaves remainder == |dividend|, so the
                    // dividend-sign fix-up below restores src1 into HI.
                    if (is_div) begin
                        hi_o <= rem_neg ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
                        if (div_zero) begin
                            lo_o <= '1;
                        end else begin
                            lo_o <= res_neg ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                        end
                    end else begin
                        {hi_o, lo_o} <= res_neg ? ('0 - acc) : acc;
                    end
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: vector table plus hand-written
// handshake, MTHI/MTLO and reset-abort sequences.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int passed = 0;
    int total  = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Starting at the negedge of cycle first_cyc, returns the cycle in which
    // done_o is seen (-1 on timeout) and how many sampled cycles had busy_o=1.
    task automatic wait_done(input int first_cyc, output int done_cyc, output int busy_cnt);
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = first_cyc; c < 80; c++) begin
            if (done_o) begin
                done_cyc = c;
                break;
            end
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int dc, bc;
        issue(v.op, v.a, v.b);
        wait_done(1, dc, bc);
        check({tag, " done cycle"}, dc, 34);
        check({tag, " busy cycles"}, bc, 33);
        check({tag, " busy in done"}, {31'b0, busy_o}, 32'd0);
        check({tag, " hi"}, hi_o, v.exp_hi);
        check({tag, " lo"}, lo_o, v.exp_lo);
    endtask

    initial begin
        int dc, bc, seen;

        vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[4] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{MDU_DIVU,  32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
        vecs[7] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[9] = '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

        repeat (3) @(negedge clk_i);
        check("reset hi", hi_o, 32'd0);
        check("reset lo", lo_o, 32'd0);
        check("reset busy", {31'b0, busy_o}, 32'd0);
        check("reset done", {31'b0, done_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start while busy is dropped; issue in the done cycle is accepted.
        issue(MDU_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk_i);
        issue(MDU_MULT, 32'd3, 32'd3);
        wait_done(6, dc, bc);
        check("ignore done cycle", dc, 34);
        check("ignore hi", hi_o, 32'd2);
        check("ignore lo", lo_o, 32'd14);
        issue(MDU_MULT, 32'd5, 32'hFFFFFFFE);
        check("b2b single done", {31'b0, done_o}, 32'd0);
        check("b2b accepted", {31'b0, busy_o}, 32'd1);
        wait_done(1, dc, bc);
        check("b2b done cycle", dc, 34);
        check("b2b hi", hi_o, 32'hFFFFFFFF);
        check("b2b lo", lo_o, 32'hFFFFFFF6);
        @(negedge clk_i);

        // MTHI, MTLO, reserved on consecutive edges.
        op_i = MDU_MTHI; src1_i = 32'h12345678; start_i = 1'b1;
        @(negedge clk_i);
        check("mthi hi", hi_o, 32'h12345678);
        check("mthi busy", {31'b0, busy_o}, 32'd0);
        check("mthi done", {31'b0, done_o}, 32'd0);
        op_i = MDU_MTLO; src1_i = 32'hCAFEF00D;
        @(negedge clk_i);
        check("mtlo lo", lo_o, 32'hCAFEF00D);
        check("mtlo hi kept", hi_o, 32'h12345678);
        check("mtlo busy", {31'b0, busy_o}, 32'd0);
        check("mtlo done", {31'b0, done_o}, 32'd0);
        op_i = 3'b111; src1_i = 32'hDEADBEEF;
        @(negedge clk_i);
        start_i = 1'b0;
        check("rsvd hi", hi_o, 32'h12345678);
        check("rsvd lo", lo_o, 32'hCAFEF00D);
        check("rsvd busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);
        check("rsvd later busy", {31'b0, busy_o}, 32'd0);

        // Reset aborts an in-flight multiply with no HI/LO write.
        issue(MDU_MULT, 32'd9, 32'd9);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort hi", hi_o, 32'd0);
        check("abort lo", lo_o, 32'd0);
        check("abort busy", {31'b0, busy_o}, 32'd0);
        check("abort done", {31'b0, done_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen++;
        end
        check("abort no activity", seen, 0);
        run_vec('{MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42}, "post-reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit. It sits beside the single-cycle EX-stage ALU and executes the operations that ALU does not: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It owns the architectural HI/LO registers.
- It uses a start/busy/done handshake so hazard logic can stall MFHI/MFLO and further mul/div ops until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width; must equal the codebase `WIDTH.
- CNT_W, 5, iteration-counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  issue strobe from EX; sampled only while busy_o=0.
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 reserved.
- src1_i  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- src2_i  in  WIDTH  rt operand (multiplier / divisor).
- busy_o  out  1  high while an iterative operation is in flight.
- done_o  out  1  one-cycle pulse; hi_o/lo_o hold the new result in this cycle.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Reset (rst_i=0, at any time, including mid-operation):
  - State goes to IDLE and the counter clears.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0.
  - Any in-flight operation is aborted with no HI/LO write.
- States: IDLE, CALC, FIX. busy_o = (state != IDLE).
- IDLE:
  - start_i=1 with op 000-011: latch operands and op, then go to CALC with counter=0.
    - Signed ops latch operand magnitudes plus result-sign and remainder-sign flags.
  - start_i=1 with op 100 (MTHI): hi_o <= src1_i at that edge; stay IDLE; no done_o.
  - start_i=1 with op 101 (MTLO): lo_o <= src1_i at that edge; stay IDLE; no done_o.
  - Reserved ops: ignored; no state change.
- CALC: exactly WIDTH cycles, one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - On counter==WIDTH-1, go to FIX.
- FIX: one cycle.
  - Apply two's-complement sign correction for signed ops.
  - Write HI/LO at the end of the cycle, then go to IDLE.
  - done_o is registered and high for the single cycle after FIX.
- Latency: start_i accepted at edge E0 gives busy_o=1 for WIDTH+1 cycles and done_o=1 in cycle WIDTH+2 after E0 (cycle 34 for WIDTH=32). busy_o=0 in the done cycle.
- start_i while busy_o=1: ignored entirely, no queueing. Issuing control must hold the instruction.
- start_i in the done cycle is accepted normally (back-to-back issue).
- Result rules:
  - Multiply: {hi,lo} = full 2*WIDTH product. Signed for MULT, unsigned for MULTU.
  - Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero (DIV or DIVU): hi = src1_i, lo = all ones. No exception is raised.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- hi_o/lo_o hold their values except on a FIX write, an MTHI/MTLO write, or reset.

Decomposition:
- Shared package (mdu_pkg): op encodings MDU_MULT/MULTU/DIV/DIVU/MTHI/MTLO, state encodings, WIDTH/CNT_W constants.
- Top-level mul_div_unit: FSM, counter, handshake, HI/LO registers, sign fix-up.
- One natural sub-module, mdu_iter_core: the per-cycle shift-add / shift-subtract step. It is purely combinational on {acc, divisor/multiplicand, op class}.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=7 -> done_o in cycle 34 after issue; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy_o high cycles 1-33.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 10/0 -> hi=0x0000000A, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7, pulse start_i again with MULT at cycle 5 -> second start ignored; single done_o at cycle 34 with lo=14, hi=2. MULT issued in the done cycle completes 34 cycles later.
- MTHI 0x12345678 then MTLO 0xCAFEF00D on consecutive cycles -> hi/lo update at each edge, busy_o and done_o stay 0. Reserved op 111 -> no change.
- Load HI/LO via MTHI/MTLO, start MULT, assert rst_i=0 at cycle 10 -> immediate hi=lo=0, busy_o=0, no done_o pulse. After release, a new MULT 6x7 completes normally with lo=42.
